// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a byte-addressed DataMemory.
// Checks each request, splits misaligned accesses into byte accesses and extends loads.
module load_store_unit #(
  parameter int unsigned MEM_BYTES        = 2048,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWr,
  input  logic [2:0]  ReqCtrl,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqData,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespData,
  output logic [1:0]  RespErr,
  output logic [31:0] MemAddress,
  output logic [31:0] MemDataWr,
  output logic        MemDMWr,
  output logic [2:0]  MemDMCtrl,
  input  logic [31:0] MemDataRd
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  localparam logic [2:0] CTRL_B  = 3'b000;
  localparam logic [2:0] CTRL_H  = 3'b001;
  localparam logic [2:0] CTRL_W  = 3'b010;
  localparam logic [2:0] CTRL_BU = 3'b100;
  localparam logic [2:0] CTRL_HU = 3'b101;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_CTRL  = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

  state_t          state_q, state_d;
  logic            wr_q, wr_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [1:0]      k_q, k_d;
  logic            ready_q, ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [DW-1:0]   resp_data_q, resp_data_d;
  logic [1:0]      resp_err_q, resp_err_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            mem_wr_q, mem_wr_d;
  logic [2:0]      mem_ctrl_q, mem_ctrl_d;

  // Request decode: size, error conditions and alignment of the incoming request.
  logic [2:0]      req_size;
  logic            req_illegal;
  logic            req_range;
  logic            req_misaligned;
  logic [AW:0]     req_last;

  always_comb begin
    case (ReqCtrl[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
    req_illegal    = (ReqCtrl == 3'b011) || (ReqCtrl == 3'b110) || (ReqCtrl == 3'b111);
    req_last       = {1'b0, ReqAddr} + (AW+1)'(req_size) - (AW+1)'(1);
    req_range      = req_last >= (AW+1)'(MEM_BYTES);
    req_misaligned = (ReqAddr[1:0] & 2'(req_size - 3'd1)) != 2'b00;
  end

  logic [1:0]    last_k;
  logic [1:0]    k_next;
  logic [DW-1:0] assembled;

  // Next-state and next-output logic; Mem* defaults are the idle values.
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    ctrl_d       = ctrl_q;
    addr_d       = addr_q;
    data_d       = data_q;
    k_d          = k_q;
    ready_d      = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    mem_wr_d     = 1'b0;
    mem_ctrl_d   = CTRL_W;
    last_k       = (ctrl_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
    k_next       = k_q + 2'd1;
    assembled    = resp_data_q;
    assembled[{k_q, 3'b000} +: 8] = MemDataRd[7:0];

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (ReqValid && ready_q) begin
          ready_d     = 1'b0;
          wr_d        = ReqWr;
          ctrl_d      = ReqCtrl;
          addr_d      = ReqAddr;
          data_d      = ReqData;
          k_d         = 2'd0;
          resp_data_d = '0;
          resp_err_d  = ERR_OK;
          if (req_illegal) begin
            resp_err_d   = ERR_CTRL;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else if (req_range) begin
            resp_err_d   = ERR_RANGE;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else if (req_misaligned && !ALLOW_MISALIGNED) begin
            resp_err_d   = ERR_ALIGN;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else if (req_misaligned) begin
            state_d     = SPLIT;
            mem_addr_d  = ReqAddr;
            mem_ctrl_d  = ReqWr ? CTRL_B : CTRL_BU;
            mem_wdata_d = ReqWr ? DW'(ReqData[7:0]) : '0;
            mem_wr_d    = ReqWr;
          end else begin
            state_d     = ACCESS;
            mem_addr_d  = ReqAddr;
            mem_ctrl_d  = ReqCtrl;
            mem_wdata_d = ReqWr ? ReqData : '0;
            mem_wr_d    = ReqWr;
          end
        end
      end
      ACCESS: begin
        if (!wr_q) resp_data_d = MemDataRd;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      SPLIT: begin
        if (!wr_q) resp_data_d = assembled;
        if (k_q == last_k) begin
          if (!wr_q) begin
            case (ctrl_q)
              CTRL_H:  resp_data_d = {{16{assembled[15]}}, assembled[15:0]};
              CTRL_HU: resp_data_d = {16'h0000, assembled[15:0]};
              default: resp_data_d = assembled;
            endcase
          end
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          k_d         = k_next;
          mem_addr_d  = addr_q + AW'(k_next);
          mem_ctrl_d  = wr_q ? CTRL_B : CTRL_BU;
          mem_wdata_d = wr_q ? DW'(data_q[{k_next, 3'b000} +: 8]) : '0;
          mem_wr_d    = wr_q;
        end
      end
      RESP: begin
        if (RespReady) begin
          resp_valid_d = 1'b0;
          ready_d      = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      ctrl_q       <= CTRL_W;
      addr_q       <= '0;
      data_q       <= '0;
      k_q          <= 2'd0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= ERR_OK;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wr_q     <= 1'b0;
      mem_ctrl_q   <= CTRL_W;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      ctrl_q       <= ctrl_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      k_q          <= k_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wr_q     <= mem_wr_d;
      mem_ctrl_q   <= mem_ctrl_d;
    end
  end

  // DataMemory writes on any input change, so the write strobe must die with Reset itself.
  assign MemDMWr    = mem_wr_q & ~Reset;
  assign MemAddress = mem_addr_q;
  assign MemDataWr  = mem_wdata_q;
  assign MemDMCtrl  = mem_ctrl_q;
  assign ReqReady   = ready_q;
  assign RespValid  = resp_valid_q;
  assign RespData   = resp_data_q;
  assign RespErr    = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: behavioural DataMemory, one misalign-capable
// instance and one instance with misaligned accesses disabled.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0;
  logic [2:0]  req_ctrl = 3'b010;
  logic [31:0] req_addr = '0, req_data = '0;
  logic        req_ready, resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;
  logic [31:0] mem_address, mem_data_wr, mem_data_rd;
  logic        mem_dmwr;
  logic [2:0]  mem_dmctrl;

  logic        b_req_valid = 1'b0;
  logic [2:0]  b_req_ctrl = 3'b010;
  logic [31:0] b_req_addr = '0;
  logic        b_req_ready, b_resp_valid;
  logic [31:0] b_resp_data, b_mem_address, b_mem_data_wr;
  logic [1:0]  b_resp_err;
  logic        b_mem_dmwr;
  logic [2:0]  b_mem_dmctrl;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(2048), .ALLOW_MISALIGNED(1'b1)) dut (
    .Clk(clk), .Reset(rst), .ReqValid(req_valid), .ReqReady(req_ready), .ReqWr(req_wr),
    .ReqCtrl(req_ctrl), .ReqAddr(req_addr), .ReqData(req_data), .RespValid(resp_valid),
    .RespReady(resp_ready), .RespData(resp_data), .RespErr(resp_err), .MemAddress(mem_address),
    .MemDataWr(mem_data_wr), .MemDMWr(mem_dmwr), .MemDMCtrl(mem_dmctrl), .MemDataRd(mem_data_rd));

  load_store_unit #(.MEM_BYTES(2048), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .Clk(clk), .Reset(rst), .ReqValid(b_req_valid), .ReqReady(b_req_ready), .ReqWr(1'b0),
    .ReqCtrl(b_req_ctrl), .ReqAddr(b_req_addr), .ReqData(32'h0), .RespValid(b_resp_valid),
    .RespReady(1'b1), .RespData(b_resp_data), .RespErr(b_resp_err), .MemAddress(b_mem_address),
    .MemDataWr(b_mem_data_wr), .MemDMWr(b_mem_dmwr), .MemDMCtrl(b_mem_dmctrl), .MemDataRd(32'h0));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural DataMemory: combinational extended read, write at the clock edge.
  logic [7:0]  mem [0:2047];
  logic        mem_init = 1'b0;
  int          wr_count = 0;
  logic [31:0] wr_addr_log [$];
  logic [31:0] wr_data_log [$];
  logic [2:0]  wr_ctrl_log [$];
  logic        b_wr_seen = 1'b0;
  logic [10:0] ma;
  logic [7:0]  rb0, rb1, rb2, rb3;

  assign ma  = mem_address[10:0];
  assign rb0 = mem[ma];
  assign rb1 = mem[11'(ma + 11'd1)];
  assign rb2 = mem[11'(ma + 11'd2)];
  assign rb3 = mem[11'(ma + 11'd3)];

  always_comb begin
    case (mem_dmctrl)
      3'b000:  mem_data_rd = {{24{rb0[7]}}, rb0};
      3'b100:  mem_data_rd = {24'h0, rb0};
      3'b001:  mem_data_rd = {{16{rb1[7]}}, rb1, rb0};
      3'b101:  mem_data_rd = {16'h0, rb1, rb0};
      default: mem_data_rd = {rb3, rb2, rb1, rb0};
    endcase
  end

  always @(posedge clk) begin
    cyc++;
    if (b_mem_dmwr) b_wr_seen = 1'b1;
    if (!mem_init) begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 7 + 3);
      mem_init = 1'b1;
    end else if (mem_dmwr) begin
      wr_count++;
      wr_addr_log.push_back(mem_address);
      wr_data_log.push_back(mem_data_wr);
      wr_ctrl_log.push_back(mem_dmctrl);
      mem[ma] = mem_data_wr[7:0];
      if (mem_dmctrl[1:0] != 2'b00) mem[11'(ma + 11'd1)] = mem_data_wr[15:8];
      if (mem_dmctrl[1:0] == 2'b10) begin
        mem[11'(ma + 11'd2)] = mem_data_wr[23:16];
        mem[11'(ma + 11'd3)] = mem_data_wr[31:24];
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb [$];
  logic resp_seen = 1'b0;

  // Response monitor: compares the first cycle of each response against the scoreboard.
  always @(negedge clk) begin
    if (resp_valid && !resp_seen) begin
      exp_t e;
      resp_seen = 1'b1;
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'(resp_valid), 32'h0);
      end else begin
        e = sb.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_err", 32'(resp_err), 32'(e.err));
        check("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end else if (!resp_valid) begin
      resp_seen = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic do_req(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_data,
                        input logic [1:0] exp_err, input int exp_lat);
    int guard = 0;
    exp_t e;
    req_valid = 1'b1;
    req_wr    = wr;
    req_ctrl  = ctrl;
    req_addr  = addr;
    req_data  = data;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("req_accept_timeout", 32'(req_ready), 32'h1);
      req_valid = 1'b0;
      return;
    end
    e.data = exp_data;
    e.err  = exp_err;
    e.lat  = exp_lat;
    e.acc  = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!(sb.size() == 0 && req_ready && !resp_valid) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("idle_timeout", 32'(sb.size()), 32'h0);
  endtask

  task automatic clear_log();
    wr_count = 0;
    wr_addr_log.delete();
    wr_data_log.delete();
    wr_ctrl_log.delete();
  endtask

  // Instance with misaligned accesses disabled: every request here is an error, latency 1.
  task automatic b_req(input logic [2:0] ctrl, input logic [31:0] addr, input logic [1:0] exp_err,
                       input string tag);
    check({tag, "_ready"}, 32'(b_req_ready), 32'h1);
    b_req_valid = 1'b1;
    b_req_ctrl  = ctrl;
    b_req_addr  = addr;
    @(negedge clk);
    b_req_valid = 1'b0;
    check({tag, "_valid"}, 32'(b_resp_valid), 32'h1);
    check({tag, "_err"}, 32'(b_resp_err), 32'(exp_err));
    check({tag, "_data"}, b_resp_data, 32'h0);
    @(negedge clk);
  endtask

  logic [7:0] p5, p6;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'h0);
    check("rst_mem_addr", mem_address, 32'h0);
    check("rst_mem_wdata", mem_data_wr, 32'h0);
    check("rst_mem_dmwr", 32'(mem_dmwr), 32'h0);
    check("rst_mem_ctrl", 32'(mem_dmctrl), 32'h2);

    // Aligned word store then load.
    clear_log();
    do_req(1'b1, 3'b010, 32'h100, 32'h11223344, 32'h0, 2'b00, 2);
    wait_idle();
    check("sw_wr_cycles", 32'(wr_count), 32'h1);
    if (wr_count == 1) begin
      check("sw_wr_addr", wr_addr_log[0], 32'h100);
      check("sw_wr_data", wr_data_log[0], 32'h11223344);
      check("sw_wr_ctrl", 32'(wr_ctrl_log[0]), 32'h2);
    end
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 32'h11223344, 2'b00, 2);
    wait_idle();

    // Byte store, signed and unsigned byte loads.
    do_req(1'b1, 3'b000, 32'h7, 32'h80, 32'h0, 2'b00, 2);
    do_req(1'b0, 3'b000, 32'h7, 32'h0, 32'hFFFFFF80, 2'b00, 2);
    do_req(1'b0, 3'b100, 32'h7, 32'h0, 32'h00000080, 2'b00, 2);
    wait_idle();

    // Misaligned word store splits into four byte writes.
    clear_log();
    do_req(1'b1, 3'b010, 32'h203, 32'hA1B2C3D4, 32'h0, 2'b00, 5);
    wait_idle();
    check("split_wr_cycles", 32'(wr_count), 32'h4);
    for (int i = 0; i < 4 && i < wr_count; i++) begin
      check("split_wr_addr", wr_addr_log[i], 32'h203 + 32'(i));
      check("split_wr_ctrl", 32'(wr_ctrl_log[i]), 32'h0);
      check("split_wr_data", wr_data_log[i], 32'(8'(32'hA1B2C3D4 >> (8 * i))));
    end
    do_req(1'b0, 3'b101, 32'h205, 32'h0, 32'h0000A1B2, 2'b00, 3);
    do_req(1'b0, 3'b001, 32'h204, 32'h0, 32'hFFFFB2C3, 2'b00, 2);
    do_req(1'b0, 3'b010, 32'h205, 32'h0, 32'h3B34A1B2, 2'b00, 5);
    wait_idle();

    // Range and control errors, plus the last in-range word.
    clear_log();
    do_req(1'b0, 3'b010, 32'h7FE, 32'h0, 32'h0, 2'b10, 1);
    do_req(1'b0, 3'b000, 32'h800, 32'h0, 32'h0, 2'b10, 1);
    do_req(1'b0, 3'b010, 32'hFFFFFFFF, 32'h0, 32'h0, 2'b10, 1);
    do_req(1'b0, 3'b011, 32'hFFFFFFF0, 32'h0, 32'h0, 2'b11, 1);
    do_req(1'b1, 3'b111, 32'h10, 32'hDEADBEEF, 32'h0, 2'b11, 1);
    do_req(1'b1, 3'b010, 32'h7FE, 32'hDEADBEEF, 32'h0, 2'b10, 1);
    wait_idle();
    check("err_no_writes", 32'(wr_count), 32'h0);
    do_req(1'b0, 3'b010, 32'h7FC, 32'h0, 32'hFCF5EEE7, 2'b00, 2);
    wait_idle();

    // Response back-pressure.
    resp_ready = 1'b0;
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 32'h11223344, 2'b00, 2);
    for (int g = 0; g < 20 && !resp_valid; g++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(resp_valid), 32'h1);
      check("hold_data", resp_data, 32'h11223344);
      check("hold_req_ready", 32'(req_ready), 32'h0);
      if (i < 4) @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("post_hs_ready", 32'(req_ready), 32'h1);
    check("post_hs_valid", 32'(resp_valid), 32'h0);
    do_req(1'b0, 3'b100, 32'h7, 32'h0, 32'h00000080, 2'b00, 2);
    wait_idle();

    // Reset during byte 2 of a split store.
    clear_log();
    p5 = mem[11'h305];
    p6 = mem[11'h306];
    check("rst_split_ready", 32'(req_ready), 32'h1);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_ctrl  = 3'b010;
    req_addr  = 32'h303;
    req_data  = 32'hCAFEBABE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_split_dmwr", 32'(mem_dmwr), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_split_valid", 32'(resp_valid), 32'h0);
    check("rst_split_idle", 32'(req_ready), 32'h1);
    check("rst_split_wrs", 32'(wr_count), 32'h2);
    check("rst_split_b0", 32'(mem[11'h303]), 32'hBE);
    check("rst_split_b1", 32'(mem[11'h304]), 32'hBA);
    check("rst_split_b2", 32'(mem[11'h305]), 32'(p5));
    check("rst_split_b3", 32'(mem[11'h306]), 32'(p6));
    do_req(1'b0, 3'b010, 32'h303, 32'h0, {p6, p5, 16'hBABE}, 2'b00, 5);
    wait_idle();

    // Misaligned disabled.
    b_req(3'b010, 32'h2, 2'b01, "na_misalign");
    b_req(3'b001, 32'h7FF, 2'b10, "na_range");
    b_req(3'b110, 32'h4, 2'b11, "na_ctrl");
    check("na_no_writes", 32'(b_wr_seen), 32'h0);

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
